// File: rtl/uart2sys_pkg.sv
// Shared definitions for the UART-to-system word unpacker: default sizes and FSM encoding.
package uart2sys_pkg;

  localparam int DEF_IN_W     = 64;
  localparam int DEF_OUT_W    = 32;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_HI_FIRST = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/uart2sys_sfifo.sv
// Synchronous first-word-fall-through FIFO with flush; a push on full is taken only alongside a pop.
module uart2sys_sfifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem[rd_ptr_q[AW-1:0]];

  // On full, the slot being written is the head, which leaves the FIFO on this same edge.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart2sys_unpack.sv
// Splits IN_W words from a FIFO into RATIO system writes of OUT_W bits at wrapping sequential addresses.
module uart2sys_unpack
  import uart2sys_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int HI_FIRST = DEF_HI_FIRST
) (
  input  logic              clk_cpu,
  input  logic              rstn,
  input  logic [IN_W-1:0]   data_i,
  input  logic              data_vld_i,
  output logic              data_rdy_o,
  input  logic [ADDR_W-1:0] addr_init,
  input  logic              addr_init_vld_i,
  input  logic [ADDR_W-1:0] addr_last_i,
  input  logic              sys_stall_i,
  output logic [OUT_W-1:0]  sys_data_o,
  output logic [ADDR_W-1:0] sys_addr_o,
  output logic              sys_wren_o,
  output logic [31:0]       word_cnt_o,
  output logic              ovf_o,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  // Handshake: a word is taken on an edge where data_vld_i && data_rdy_o and no flush is
  // requested; data_rdy_o is high when the FIFO has room or its head leaves on the same edge.

  state_e            state_q, state_d;
  logic [IN_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OUT_W-1:0]  sys_data_q, sys_data_d;
  logic [ADDR_W-1:0] sys_addr_q, sys_addr_d;
  logic              wren_q, wren_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IN_W-1:0]   fifo_rdata;
  logic              last_slice;

  function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] w,
                                                input logic [IDX_W-1:0] k);
    int pos;
    pos = (HI_FIRST != 0) ? (RATIO - 1 - int'(k)) : int'(k);
    return w[pos*OUT_W +: OUT_W];
  endfunction

  assign last_slice = (idx_q == IDX_W'(RATIO - 1));
  assign fifo_pop   = !addr_init_vld_i && !fifo_empty && !sys_stall_i &&
                      ((state_q == ST_WAIT) || ((state_q == ST_EMIT) && last_slice));
  assign data_rdy_o = !fifo_full || fifo_pop;
  assign fifo_push  = data_vld_i && data_rdy_o && !addr_init_vld_i;

  uart2sys_sfifo #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_cpu),
    .rst_ni  (rstn),
    .flush_i (addr_init_vld_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (data_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    sys_data_d = sys_data_q;
    sys_addr_d = sys_addr_q;
    wren_d     = 1'b0;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q | (data_vld_i && !data_rdy_o);
    if (addr_init_vld_i) begin
      state_d = ST_WAIT;
      idx_d   = '0;
      addr_d  = addr_init;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
          addr_d  = addr_init;
        end
        ST_WAIT: begin
          if (fifo_pop) begin
            hold_d  = fifo_rdata;
            idx_d   = '0;
            state_d = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (!sys_stall_i) begin
            wren_d     = 1'b1;
            sys_data_d = slice_of(hold_q, idx_q);
            sys_addr_d = addr_q;
            addr_d     = (addr_q == addr_last_i) ? addr_init : addr_q + 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (last_slice) begin
              idx_d = '0;
              // Back-to-back words continue without a bubble cycle.
              if (fifo_pop) hold_d  = fifo_rdata;
              else          state_d = ST_WAIT;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      sys_data_q <= '0;
      sys_addr_q <= '0;
      wren_q     <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      sys_data_q <= sys_data_d;
      sys_addr_q <= sys_addr_d;
      wren_q     <= wren_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign sys_data_o  = sys_data_q;
  assign sys_addr_o  = sys_addr_q;
  assign sys_wren_o  = wren_q;
  assign word_cnt_o  = cnt_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = !fifo_empty || (state_q == ST_EMIT);
  assign dbg_state_o = state_q;

endmodule

// File: doc/uart2sys_unpack.md
UART2SYS_UNPACK -- requirements
Module: uart2sys_unpack

Interface
REQ-001 SHALL have parameter IN_W, default 64, the input word width.
REQ-002 SHALL have parameter OUT_W, default 32, the system word width; IN_W SHALL be an integer multiple of OUT_W, RATIO = IN_W/OUT_W >= 1.
REQ-003 SHALL have parameter ADDR_W, default 16, the system address width.
REQ-004 SHALL have parameter DEPTH, default 16, the input FIFO depth in IN_W entries; power of 2, >= 2.
REQ-005 SHALL have parameter HI_FIRST, default 0; 0 = slice [OUT_W-1:0] emitted first, 1 = most-significant slice first.
REQ-006 SHALL use one clock and an asynchronous active-low reset: clk_cpu  in  1  sole clock, all logic on rising edge.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 data_i  in  IN_W  input word.
REQ-009 data_vld_i  in  1  input word strobe.
REQ-010 data_rdy_o  out  1  FIFO not full; a write is accepted when data_vld_i && data_rdy_o.
REQ-011 addr_init  in  ADDR_W  start (and wrap) address.
REQ-012 addr_init_vld_i  in  1  one-cycle flush and address load.
REQ-013 addr_last_i  in  ADDR_W  last address before wrap to addr_init.
REQ-014 sys_stall_i  in  1  system back-pressure; when high, no write is emitted.
REQ-015 sys_data_o  out  OUT_W, sys_addr_o  out  ADDR_W, sys_wren_o  out  1  registered system write port.
REQ-016 word_cnt_o  out  32  writes emitted since last flush, saturating at 0xFFFF_FFFF.
REQ-017 ovf_o  out  1  sticky: data_vld_i seen while data_rdy_o low.
REQ-018 busy_o  out  1  FIFO non-empty or a word is partly emitted.

Function
REQ-019 The FIFO SHALL be synchronous, first-word-fall-through; a dropped write (full) SHALL NOT alter FIFO contents.
REQ-020 The FSM SHALL have states IDLE, WAIT and EMIT; IDLE -> WAIT unconditionally, loading the address register from addr_init.
REQ-021 In WAIT, with FIFO non-empty and sys_stall_i low: pop the head into a holding register, slice index = 0, go to EMIT; otherwise remain in WAIT.
REQ-022 In EMIT, each cycle with sys_stall_i low SHALL register one write: sys_wren_o=1, sys_data_o = current slice, sys_addr_o = current address; then advance the address and the slice index.
REQ-023 After the RATIO-th slice: if the FIFO is non-empty, pop the head and stay in EMIT (no bubble); otherwise go to WAIT.
REQ-024 In any cycle without an emitted write (stall, WAIT, IDLE), sys_wren_o SHALL be 0 and sys_data_o/sys_addr_o SHALL hold their values.
REQ-025 Latency: a word accepted at edge N into an idle, empty block SHALL produce its first sys_wren_o at edge N+2.
REQ-026 Address advance: if current == addr_last_i, next = addr_init; otherwise next = current+1 modulo 2^ADDR_W.
REQ-027 addr_init_vld_i SHALL take priority over all other events: empty the FIFO, abandon the partly emitted word, clear word_cnt_o and ovf_o, load addr_init, and go to WAIT.
REQ-028 A data_vld_i in the same cycle as addr_init_vld_i SHALL be dropped, without setting ovf_o.
REQ-029 A simultaneous push and pop on a full FIFO SHALL be accepted.

Reset
REQ-030 On rstn low, asynchronously: FSM = IDLE, FIFO empty, sys_wren_o=0, sys_data_o=0, sys_addr_o=0, word_cnt_o=0, ovf_o=0, busy_o=0, and data_rdy_o=1.
REQ-031 Reset asserted mid-EMIT SHALL discard the remaining slices; no write SHALL follow reset release until new data is accepted.

Structure
REQ-032 State encodings and default parameter values SHALL live in a shared package, uart2sys_pkg.
REQ-033 The FIFO SHALL be a separate sub-module, uart2sys_sfifo (parameters WIDTH, DEPTH).

Verification
REQ-034 addr_init=0x0100, word 0x1111_2222_3333_4444 -> writes (0x0100,0x3333_4444) then (0x0101,0x1111_2222) on consecutive cycles starting at edge N+2; word_cnt_o=2.
REQ-035 HI_FIRST=1, same stimulus -> 0x1111_2222 at 0x0100, then 0x3333_4444 at 0x0101.
REQ-036 DEPTH=16, sys_stall_i high, 17 back-to-back words -> 16 accepted, data_rdy_o=0, ovf_o=1; on release, 32 gap-free writes at consecutive addresses.
REQ-037 addr_init=0x0010, addr_last_i=0x0012, 2 words -> addresses 0x0010, 0x0011, 0x0012, 0x0010.
REQ-038 addr_init_vld_i after the first slice, addr_init=0x0200 -> second slice never written; FIFO empty, word_cnt_o=0; next word writes at 0x0200.
REQ-039 rstn pulsed low mid-EMIT -> all outputs at reset values immediately; no write after release until new input.
